// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that adds two WIDTH-bit operands LSB-first,
// one bit per clock, through a full-adder cell with a registered carry.
// Configuration macro: SERIAL_ADDER_SUB_EN adds the sub port.
// With sub=1 the block computes a - b: b is inverted into the cell and the
// carry is seeded to 1, so cout=1 means no borrow.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. Operands offered while
// in_ready is low are ignored, not queued. out_valid stays high with sum and
// cout held stable until the edge where out_ready is also high.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Full-adder cell outputs for the current bit
   logic             ha1_s;
   logic             ha1_c;
   logic             ha2_c;
   logic             sum_bit_d;
   logic             carry_d;
   logic             last_bit;

   // Operand latch values (b optionally inverted, carry seed)
   logic [WIDTH-1:0] b_load_d;
   logic             carry_seed_d;

   // Full-adder cell: two half adders plus OR on the LSBs and the carry
   always_comb begin
      ha1_s     = a_q[0] ^ b_q[0];
      ha1_c     = a_q[0] & b_q[0];
      ha2_c     = ha1_s & carry_q;
      sum_bit_d = ha1_s ^ carry_q;
      carry_d   = ha1_c | ha2_c;
      last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Operand conditioning at acceptance: subtract inverts b and seeds carry
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_load_d     = sub ? ~b : b;
      carry_seed_d = sub;
`else
      b_load_d     = b;
      carry_seed_d = 1'b0;
`endif
   end

   // Control FSM with datapath registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b_load_d;
                  carry_q    <= carry_seed_d;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               sum_q   <= {sum_bit_d, sum_q[WIDTH-1:1]};
               a_q     <= {1'b0, a_q[WIDTH-1:1]};
               b_q     <= {1'b0, b_q[WIDTH-1:1]};
               carry_q <= carry_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  cout_q      <= carry_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases plus a random sweep, checked
// against an arithmetic reference model through an expected-result queue.
module tb_serial_adder;

   localparam int WIDTH = 8;
   localparam int CLK_P = 10;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
   logic [1:0]       dbg_state;

   logic [WIDTH:0]   exp_q[$];
   int               compared;
   int               mismatched;
   time              acc_t;
   bit               rand_done;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #(CLK_P/2) clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: plain integer arithmetic, result is {cout, sum}
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic sv);
      int unsigned ai, bi, r;
      ai = av;
      bi = bv;
      if (sv) begin
         r = (ai - bi) % (1 << WIDTH);
         return {(ai >= bi) ? 1'b1 : 1'b0, r[WIDTH-1:0]};
      end
      r = ai + bi;
      return r[WIDTH:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: offer operands, push expected result at the accepting edge
   task automatic send_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
      bit ok;
      ok       = 1'b0;
      a        = av;
      b        = bv;
      sub      = sv;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         acc_t = $time;
         exp_q.push_back(model(av, bv, sv));
         #1;
      end else begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: in_ready low for 200 cycles, a=0x%0h b=0x%0h", av, bv);
      end
      in_valid = 1'b0;
      sub      = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // monitor: compare at every output handshake, check stability while stalled
   initial begin : monitor
      logic [WIDTH:0] got;
      logic [WIDTH:0] held;
      bit             stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            got = {cout, sum};
            if (stalled && out_valid) check("held_result_stable", got, held);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_result: got 0x%0h with nothing expected", got);
               end else begin
                  check("result", got, exp_q.pop_front());
               end
               stalled = 1'b0;
            end else if (out_valid) begin
               stalled = 1'b1;
               held    = got;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      time t1;
      compared   = 0;
      mismatched = 0;
      rand_done  = 1'b0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      sub        = 1'b0;
      out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      rst = 1'b0;
      step();

      // 0 + 0 with latency and in_ready/busy during the operation
      send_op(8'h00, 8'h00, 1'b0);
      for (int i = 1; i <= WIDTH; i++) begin
         check("lat_out_valid_low", out_valid, 0);
         check("op_in_ready_low", in_ready, 0);
         check("op_busy_high", busy, 1);
         step();
      end
      check("lat_out_valid_high", out_valid, 1);
      out_ready = 1'b1;
      drain();
      check("idle_in_ready", in_ready, 1);

      // back-to-back with out_ready held high
      send_op(8'hFF, 8'h01, 1'b0);
      t1 = acc_t;
      send_op(8'hA5, 8'h5A, 1'b0);
      check("b2b_spacing_cycles", 32'((acc_t - t1) / CLK_P), WIDTH + 2);
      drain();

      // stall for 5 cycles, in_valid pulses ignored
      out_ready = 1'b0;
      send_op(8'h80, 8'h80, 1'b0);
      for (int i = 0; i < 50 && !out_valid; i++) step();
      check("stall_out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a        = 8'($urandom);
         b        = 8'($urandom);
         check("stall_in_ready_low", in_ready, 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // asynchronous reset in the 4th shift cycle
      send_op(8'h33, 8'h11, 1'b0);
      repeat (3) step();
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_sum", sum, 0);
      check("arst_cout", cout, 0);
      exp_q.delete();
      step();
      rst = 1'b0;
      step();
      send_op(8'h01, 8'h02, 1'b0);
      drain();

`ifdef SERIAL_ADDER_SUB_EN
      send_op(8'h05, 8'h07, 1'b1);
      send_op(8'h07, 8'h05, 1'b1);
      drain();
`endif

      // random sweep with random out_ready stalls
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
               send_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
`else
               send_op(8'($urandom), 8'($urandom), 1'b0);
`endif
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               step();
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: accepts two WIDTH-bit operands over a valid/ready handshake and adds them LSB-first, one bit per clock. The per-bit datapath is a full-adder cell (two half-adder stages plus OR) with a registered carry. The result (sum plus carry-out) is presented on a second valid/ready handshake. It sits downstream of the operand source and upstream of whatever consumes sums, trading latency for area compared with the parallel adder cells.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  subtract select, sampled with operands (present only with SERIAL_ADDER_SUB_EN)
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, registered
- cout  output  1  carry-out; for subtract, 1 = no borrow (a ≥ b)
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a and b into shift registers, clear the bit counter, and set carry=0 (carry=1 with b inverted when sub=1). Go to SHIFT.
- SHIFT: each cycle computes s = a[0]^b[0]^c and c' = a[0]&b[0] | c&(a[0]^b[0]). s shifts into the MSB of the sum register. The operand registers shift right by one. Counter increments. After WIDTH shift cycles, cout takes the final carry and the FSM goes to DONE.
- DONE: out_valid=1; sum and cout held stable. On out_valid&out_ready the FSM returns to IDLE.
- in_valid is ignored outside IDLE; no operand queueing.
- Arithmetic is modulo 2^WIDTH; overflow is visible only through cout.
- Counter width: clog2(WIDTH)+1. The counter never wraps within an operation.
- Reset, at any time including mid-SHIFT or DONE: the operation is discarded and the FSM enters IDLE immediately.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry=0, counter=0.

## Timing
- Input handshake at edge E0.
- SHIFT occupies edges E1..E_WIDTH.
- out_valid goes high after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Output handshake at edge Ek → in_ready high from the next cycle.
- Minimum spacing between accepted operations: WIDTH+2 cycles (out_ready held high).
- out_ready may be held high in advance; the result still lasts at least one cycle.
- All outputs are registered or decoded only from FSM state; there is no combinational path from input to output.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1, the result is a − b: b bits are inverted into the cell and carry is seeded to 1.
  - cout=1 means no borrow.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port.
  - Add only; carry is seeded to 0.

## Test plan
- Reset, then a=0x00, b=0x00 → sum=0x00, cout=0, out_valid exactly 8 cycles after acceptance, in_ready=0 during the operation.
- a=0xFF, b=0x01 → sum=0x00, cout=1. Then back-to-back a=0xA5, b=0x5A with out_ready held high → sum=0xFF, cout=0, accepted 10 cycles after the first.
- a=0x80, b=0x80 with out_ready low for 5 cycles after out_valid → sum=0x00, cout=1 held stable. in_valid pulses during this time are ignored.
- Assert rst for 1 cycle at the 4th SHIFT cycle of a=0x33, b=0x11 → all outputs return to reset values asynchronously. A new a=0x01, b=0x02 afterwards → sum=0x03, cout=0.
- SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1 → sum=0x02, cout=1.
- Random sweep of 1000 operand pairs with random out_ready stalls → every result matches (a+b) mod 256, with cout equal to bit 8 of the true sum.
